// File: rtl/ysyx_23060332_ifu_pkg.sv
//------------------------------------------------------------------------------
// Module  : ysyx_23060332_ifu_pkg
// Brief   : Shared widths, reset constants and IFU state encodings.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_23060332_ifu_pkg;

  localparam int unsigned c_inst_bus      = 32;
  localparam int unsigned c_inst_addr_bus = 32;

  localparam logic [c_inst_addr_bus-1:0] c_reset_pc = 32'h8000_0000;
  localparam logic [c_inst_bus-1:0]      c_inst_nop = 32'h0000_0013;

  localparam logic [1:0] c_ifu_req  = 2'd0;
  localparam logic [1:0] c_ifu_wait = 2'd1;
  localparam logic [1:0] c_ifu_out  = 2'd2;

  function automatic logic is_word_aligned(input logic [c_inst_addr_bus-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_ifu_pc_reg.sv
//------------------------------------------------------------------------------
// Module  : ysyx_23060332_ifu_pc_reg
// Brief   : PC register with next-PC mux (redirect > pc+4 > hold).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060332_ifu_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [c_inst_addr_bus-1:0] RESET_PC = c_reset_pc
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_redirect_valid,
  input  logic [c_inst_addr_bus-1:0] i_redirect_pc,
  input  logic                       i_advance,
  output logic [c_inst_addr_bus-1:0] o_pc,
  output logic [c_inst_addr_bus-1:0] o_pc_next
);

  logic [c_inst_addr_bus-1:0] r_pc;
  logic [c_inst_addr_bus-1:0] w_pc_inc;

  // Natural 32-bit wrap: 0xFFFF_FFFC + 4 becomes 0.
  assign w_pc_inc = r_pc + 32'd4;

  always_comb begin
    o_pc_next = r_pc;
    if (i_redirect_valid) begin
      o_pc_next = i_redirect_pc;
    end else if (i_advance) begin
      o_pc_next = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= o_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_ifu.sv
//------------------------------------------------------------------------------
// Module  : ysyx_23060332_ifu
// Brief   : Instruction fetch unit, single outstanding request, redirectable.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter logic [c_inst_addr_bus-1:0] RESET_PC = c_reset_pc,
  parameter logic [c_inst_bus-1:0]      NOP_INST = c_inst_nop
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [c_inst_addr_bus-1:0] mem_req_addr,
  input  logic                       mem_resp_valid,
  input  logic [c_inst_bus-1:0]      mem_resp_data,
  input  logic                       mem_resp_err,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [c_inst_bus-1:0]      inst_o,
  output logic [c_inst_addr_bus-1:0] inst_addr,
  output logic                       inst_fault,
  input  logic                       redirect_valid,
  input  logic [c_inst_addr_bus-1:0] redirect_pc
);

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_next;
  logic                       r_drop;
  logic                       w_drop_next;
  logic                       r_req_valid;
  logic [c_inst_bus-1:0]      r_inst;
  logic [c_inst_addr_bus-1:0] r_inst_addr;
  logic                       r_inst_fault;

  logic                       w_advance;
  logic                       w_load_resp;
  logic                       w_load_fault;
  logic                       w_pc_aligned;
  logic [c_inst_addr_bus-1:0] w_pc;
  logic [c_inst_addr_bus-1:0] w_pc_next;

  ysyx_23060332_ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_advance        (w_advance),
    .o_pc             (w_pc),
    .o_pc_next        (w_pc_next)
  );

  assign w_pc_aligned = is_word_aligned(w_pc);

  // State register. The request-valid flag is registered from the next state
  // so it is low throughout reset and rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ifu_req;
      r_drop       <= 1'b0;
      r_req_valid  <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drop      <= w_drop_next;
      r_req_valid <= (w_state_next == c_ifu_req) && is_word_aligned(w_pc_next);
      if (w_load_fault) begin
        r_inst       <= NOP_INST;
        r_inst_addr  <= w_pc;
        r_inst_fault <= 1'b1;
      end else if (w_load_resp) begin
        r_inst       <= mem_resp_err ? NOP_INST : mem_resp_data;
        r_inst_addr  <= w_pc;
        r_inst_fault <= mem_resp_err;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    case (r_state)
      c_ifu_req: begin
        if (!w_pc_aligned) begin
          if (!redirect_valid) begin
            w_state_next = c_ifu_out;
          end
        end else if (r_req_valid && mem_req_ready) begin
          w_state_next = c_ifu_wait;
          w_drop_next  = redirect_valid;
        end
      end
      c_ifu_wait: begin
        if (mem_resp_valid) begin
          w_drop_next  = 1'b0;
          w_state_next = (r_drop || redirect_valid) ? c_ifu_req : c_ifu_out;
        end else if (redirect_valid) begin
          w_drop_next = 1'b1;
        end
      end
      c_ifu_out: begin
        if (redirect_valid || inst_ready) begin
          w_state_next = c_ifu_req;
        end
      end
      default: begin
        w_state_next = c_ifu_req;
        w_drop_next  = 1'b0;
      end
    endcase
  end

  // Output logic and datapath enables.
  always_comb begin
    w_advance     = (r_state == c_ifu_out) && inst_ready;
    w_load_fault  = (r_state == c_ifu_req) && !w_pc_aligned && !redirect_valid;
    w_load_resp   = (r_state == c_ifu_wait) && mem_resp_valid && !r_drop && !redirect_valid;
    mem_req_valid = r_req_valid;
    mem_req_addr  = w_pc;
    inst_valid    = (r_state == c_ifu_out);
    inst_o        = r_inst;
    inst_addr     = r_inst_addr;
    inst_fault    = r_inst_fault;
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_ifu.sv
//------------------------------------------------------------------------------
// Module  : tb_ysyx_23060332_ifu
// Brief   : Directed cycle-table bench for the instruction fetch unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060332_ifu;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_23060332_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_addr      (inst_addr),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        irdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ia;
    logic        e_f;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic rerr, input logic irdy, input logic redir,
                              input logic [31:0] rpc, input logic e_rqv,
                              input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_inst, input logic [31:0] e_ia,
                              input logic e_f);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.rerr = rerr; v.irdy = irdy;
    v.redir = redir; v.rpc = rpc; v.e_rqv = e_rqv; v.e_addr = e_addr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_ia = e_ia; v.e_f = e_f;
    return v;
  endfunction

  task automatic chk(input string tag, input logic e_rqv, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_inst,
                     input logic [31:0] e_ia, input logic e_f);
    n_cmp++;
    if ({mem_req_valid, mem_req_addr, inst_valid, inst_o, inst_addr, inst_fault} !==
        {e_rqv, e_addr, e_iv, e_inst, e_ia, e_f}) begin
      n_bad++;
      $display("FAIL %s: got rqv=%b addr=%h iv=%b inst=%h ia=%h f=%b, want rqv=%b addr=%h iv=%b inst=%h ia=%h f=%b",
               tag, mem_req_valid, mem_req_addr, inst_valid, inst_o, inst_addr, inst_fault,
               e_rqv, e_addr, e_iv, e_inst, e_ia, e_f);
    end
  endtask

  vec_t tbl[28];

  initial begin
    //            rdy rv rdata        err ir rd rpc            rqv addr          iv inst          ia            f
    tbl[0]  = mk(1, 1, 32'h0000_0077, 0, 1, 0, 32'h0,         0, 32'h8000_0000, 0, 32'h0000_0013, 32'h0,         0);
    tbl[1]  = mk(1, 0, 32'h0,         0, 1, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0000_0013, 32'h0,         0);
    tbl[2]  = mk(0, 1, 32'h0000_0093, 0, 0, 0, 32'h0,         0, 32'h8000_0000, 0, 32'h0000_0013, 32'h0,         0);
    for (int i = 3; i <= 7; i++)
      tbl[i] = mk(0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h8000_0000, 1, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[8]  = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'h8000_0000, 1, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[9]  = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0004, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[10] = mk(0, 0, 32'h0,         0, 0, 1, 32'h8000_0100, 0, 32'h8000_0004, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[11] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h8000_0100, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[12] = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         0, 32'h8000_0100, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[13] = mk(1, 0, 32'h0,         0, 0, 1, 32'h8000_0200, 1, 32'h8000_0100, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[14] = mk(0, 1, 32'hBAD0_0001, 0, 0, 0, 32'h0,         0, 32'h8000_0200, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[15] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0200, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[16] = mk(0, 1, 32'h1111_1111, 0, 0, 1, 32'h8000_0300, 0, 32'h8000_0200, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[17] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h8000_0300, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[18] = mk(0, 1, 32'h1234_5678, 1, 0, 0, 32'h0,         0, 32'h8000_0300, 0, 32'h0000_0093, 32'h8000_0000, 0);
    tbl[19] = mk(0, 0, 32'h0,         0, 1, 1, 32'h8000_0102, 0, 32'h8000_0300, 1, 32'h0000_0013, 32'h8000_0300, 1);
    tbl[20] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h8000_0102, 0, 32'h0000_0013, 32'h8000_0300, 1);
    tbl[21] = mk(0, 0, 32'h0,         0, 0, 1, 32'hFFFF_FFFC, 0, 32'h8000_0102, 1, 32'h0000_0013, 32'h8000_0102, 1);
    tbl[22] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0013, 32'h8000_0102, 1);
    tbl[23] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0000_0013, 32'h8000_0102, 1);
    tbl[24] = mk(0, 1, 32'h0000_0493, 0, 0, 0, 32'h0,         0, 32'hFFFF_FFFC, 0, 32'h0000_0013, 32'h8000_0102, 1);
    tbl[25] = mk(0, 0, 32'h0,         0, 1, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0000_0493, 32'hFFFF_FFFC, 0);
    tbl[26] = mk(1, 0, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0000_0493, 32'hFFFF_FFFC, 0);
    tbl[27] = mk(0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 32'h0000_0000, 0, 32'h0000_0493, 32'hFFFF_FFFC, 0);

    rst_n          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    repeat (3) @(negedge clk);
    chk("reset_state", 0, 32'h8000_0000, 0, 32'h0000_0013, 32'h0, 0);
    rst_n = 1'b1;

    // Inputs are applied at each falling edge and held across the next rising edge.
    for (int i = 0; i < 28; i++) begin
      chk($sformatf("row%0d", i), tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_iv,
          tbl[i].e_inst, tbl[i].e_ia, tbl[i].e_f);
      mem_req_ready  = tbl[i].rdy;
      mem_resp_valid = tbl[i].rv;
      mem_resp_data  = tbl[i].rdata;
      mem_resp_err   = tbl[i].rerr;
      inst_ready     = tbl[i].irdy;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      @(negedge clk);
    end

    // Asynchronous reset while a request is outstanding.
    #2 rst_n = 1'b0;
    #1 chk("async_reset_mid_wait", 0, 32'h8000_0000, 0, 32'h0000_0013, 32'h0, 0);
    @(negedge clk);
    rst_n          = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFE_F00D;
    @(negedge clk);
    chk("late_resp_ignored", 1, 32'h8000_0000, 0, 32'h0000_0013, 32'h0, 0);
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    @(negedge clk);
    chk("restart_wait", 0, 32'h8000_0000, 0, 32'h0000_0013, 32'h0, 0);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0113;
    @(negedge clk);
    chk("restart_out", 0, 32'h8000_0000, 1, 32'h0000_0113, 32'h8000_0000, 0);
    mem_resp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
